adc_sample_sequencer: RTL and testbench
=======================================

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NUM_ADC, 5, number of SPI ADC channels.
- DATA_W, 16, ADC result width.
- PERIOD_W, 16, sample-period counter width.
- TIMEOUT, 1024, max clocks for one sample round.
- FIFO_ABITS, 4, log2 output FIFO depth.
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports (name, direction, width, meaning):
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run periodic sampling.
- period  in  PERIOD_W  tick every period+1 clocks.
- ch_mask  in  NUM_ADC  channels sampled per round.
- clear_err  in  1  clears sticky error flags.
- spi_ena  out  NUM_ADC  one-cycle start pulse per SPI master.
- spi_fin  in  NUM_ADC  one-cycle conversion-done pulse per master.
- spi_data  in  NUM_ADC*DATA_W  per-channel result; channel i at [i*DATA_W +: DATA_W].
- m_valid  out  1  output word available.
- m_data  out  CH_W+DATA_W  {channel index, result}.
- m_ready  in  1  consumer accepts word.
- busy  out  1  round in progress.
- round_done  out  1  one-cycle pulse at round end.
- overrun  out  1  sticky: tick dropped while busy.
- timeout_err  out  1  sticky: round aborted.
- fifo_full  out  1.
- fifo_empty  out  1.
REQ-003 SHALL define CH_W = max(1, clog2(NUM_ADC)).

Function
REQ-004 Tick counter SHALL count 0..period while enable=1, pulse tick on reaching period, reload 0; held at 0 while enable=0.
REQ-005 States SHALL be IDLE, BUSY, DRAIN.
REQ-006 IDLE with tick and ch_mask!=0: next cycle spi_ena=ch_mask for exactly one cycle; pending<=ch_mask; go BUSY. Tick with ch_mask==0 is ignored.
REQ-007 BUSY: spi_fin[i] with pending[i]=1 captures spi_data[i] into capture[i], clears pending[i], sets rdy[i]; spi_fin on non-pending channel ignored.
REQ-008 Every cycle with any rdy bit set and FIFO not full, lowest-index ready channel SHALL be pushed as {i, capture[i]} and its rdy bit cleared; one push per cycle max.
REQ-009 pending==0 moves to DRAIN; DRAIN ends when rdy==0, pulsing round_done and returning to IDLE.
REQ-010 fin at cycle F SHALL yield m_valid no earlier than F+2 with empty FIFO and no higher-priority rdy bit.
REQ-011 Tick in BUSY or DRAIN SHALL be dropped and set overrun; counter continues.
REQ-012 BUSY lasting TIMEOUT cycles SHALL clear pending, set timeout_err, go DRAIN (captured data still delivered).
REQ-013 FIFO full SHALL stall pushes (rdy held); no data lost or duplicated.
REQ-014 FIFO SHALL be show-ahead: m_data valid while m_valid; pop on m_valid&&m_ready; simultaneous push and pop when full SHALL succeed.
REQ-015 enable deasserted mid-round SHALL let round complete; no new tick.
REQ-016 clear_err SHALL clear overrun/timeout_err; a same-cycle set event wins.
REQ-017 busy SHALL be 1 in BUSY and DRAIN.

Reset
REQ-018 reset SHALL force IDLE, counter 0, pending/rdy/captures 0, FIFO empty, all outputs 0 except fifo_empty=1, regardless of state; in-flight SPI results after reset ignored.

Structure
REQ-019 Shared package SHALL hold state encoding and CH_W function.
REQ-020 Output buffer SHALL be sub-module sample_fifo (parametrised abits, dbits, show-ahead, reset, full/empty).

Verification
REQ-021 period=9, mask=5'b00101, fins 3 cycles after ena, m_ready=1 -> spi_ena every 10 clocks; words {0,D0},{2,D2} per round; round_done once/round.
REQ-022 period=3, fin delayed 20 cycles -> overrun=1, no extra spi_ena; clear_err -> overrun=0.
REQ-023 mask=5'b11111, channel 3 never fins, TIMEOUT=64 -> timeout_err=1 after 64 BUSY cycles, 4 words out, IDLE.
REQ-024 m_ready=0, FIFO_ABITS=2, 3 rounds all channels -> exactly 4 words held, no loss; release m_ready -> all 15 words in order, channels ascending within each round.
REQ-025 reset asserted mid-BUSY with pending fins -> next cycle all outputs reset values; late fins produce no output.

Source files
------------

// File: rtl/adc_sample_sequencer_pkg.sv
// Shared types and helpers for the ADC sample sequencer.
package adc_sample_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Channel-index width; a single channel still carries a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_fifo.sv
// Show-ahead output FIFO; accepts a push while full if a pop happens in the same cycle.
module sample_fifo #(
    parameter int ABITS = 4,
    parameter int DBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DBITS-1:0] din_i,
    input  logic             pop_i,
    output logic [DBITS-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [ABITS-1:0] wptr_q, rptr_q;
    logic [ABITS:0]   cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = cnt_q[ABITS];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + ABITS'(1);
            if (do_pop)  rptr_q <= rptr_q + ABITS'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (ABITS+1)'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - (ABITS+1)'(1);
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Periodic multi-channel SPI ADC sampler: starts a round per tick, collects results,
// and streams {channel, result} words through an output FIFO.
module adc_sample_sequencer
    import adc_sample_sequencer_pkg::*;
#(
    parameter int NUM_ADC    = 5,
    parameter int DATA_W     = 16,
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT    = 1024,
    parameter int FIFO_ABITS = 4,
    localparam int CH_W      = ch_width(NUM_ADC)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PERIOD_W-1:0]       period,
    input  logic [NUM_ADC-1:0]        ch_mask,
    input  logic                      clear_err,
    output logic [NUM_ADC-1:0]        spi_ena,
    input  logic [NUM_ADC-1:0]        spi_fin,
    input  logic [NUM_ADC*DATA_W-1:0] spi_data,
    output logic                      m_valid,
    output logic [CH_W+DATA_W-1:0]    m_data,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      round_done,
    output logic                      overrun,
    output logic                      timeout_err,
    output logic                      fifo_full,
    output logic                      fifo_empty
);
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    state_e              state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [TO_W-1:0]     tmo_q;
    logic [NUM_ADC-1:0]  pending_q, rdy_q, spi_ena_q;
    logic [DATA_W-1:0]   cap_q [NUM_ADC];
    logic                round_done_q, overrun_q, timeout_q;

    logic                tick, fifo_pop, push;
    logic [NUM_ADC-1:0]  fin_hit, pending_d, push_oh;
    logic [CH_W-1:0]     push_idx;
    logic [DATA_W-1:0]   push_data;

    assign tick      = enable && (cnt_q == period);
    assign fin_hit   = (state_q == BUSY) ? (spi_fin & pending_q) : '0;
    assign pending_d = pending_q & ~fin_hit;
    assign fifo_pop  = m_valid && m_ready;
    assign push      = (|rdy_q) && (!fifo_full || fifo_pop);

    // Lowest-index ready channel wins the single push slot.
    always_comb begin
        push_idx  = '0;
        push_data = '0;
        push_oh   = '0;
        for (int i = NUM_ADC - 1; i >= 0; i--) begin
            if (rdy_q[i]) begin
                push_idx  = CH_W'(i);
                push_data = cap_q[i];
            end
        end
        for (int i = 0; i < NUM_ADC; i++) begin
            push_oh[i] = push && (push_idx == CH_W'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            pending_q    <= '0;
            rdy_q        <= '0;
            spi_ena_q    <= '0;
            round_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < NUM_ADC; i++) cap_q[i] <= '0;
        end else begin
            spi_ena_q    <= '0;
            round_done_q <= 1'b0;
            cnt_q        <= (!enable || tick) ? '0 : cnt_q + PERIOD_W'(1);
            rdy_q        <= (rdy_q & ~push_oh) | fin_hit;
            for (int i = 0; i < NUM_ADC; i++) begin
                if (fin_hit[i]) cap_q[i] <= spi_data[i*DATA_W +: DATA_W];
            end

            // Set events are assigned last so they win over a same-cycle clear.
            if (clear_err) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (tick && state_q != IDLE) overrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (tick && |ch_mask) begin
                        spi_ena_q <= ch_mask;
                        pending_q <= ch_mask;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    tmo_q     <= tmo_q + TO_W'(1);
                    pending_q <= pending_d;
                    if (pending_d == '0) begin
                        state_q <= DRAIN;
                    end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                        pending_q <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rdy_q == '0) begin
                        round_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sample_fifo #(
        .ABITS(FIFO_ABITS),
        .DBITS(CH_W + DATA_W)
    ) u_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .push_i (push),
        .din_i  ({push_idx, push_data}),
        .pop_i  (fifo_pop),
        .dout_o (m_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign m_valid     = !fifo_empty;
    assign spi_ena     = spi_ena_q;
    assign busy        = (state_q != IDLE);
    assign round_done  = round_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboarded bench: an SPI responder model queues expected words as it returns results.
module tb_adc_sample_sequencer;
    localparam int NUM_ADC    = 5;
    localparam int DATA_W     = 16;
    localparam int PERIOD_W   = 16;
    localparam int TIMEOUT    = 64;
    localparam int FIFO_ABITS = 2;
    localparam int CH_W       = 3;
    localparam int MW         = CH_W + DATA_W;

    logic                      clock = 1'b0;
    logic                      reset, enable, clear_err, m_ready;
    logic [PERIOD_W-1:0]       period;
    logic [NUM_ADC-1:0]        ch_mask, spi_ena, spi_fin;
    logic [NUM_ADC*DATA_W-1:0] spi_data;
    logic                      m_valid, busy, round_done, overrun, timeout_err, fifo_full, fifo_empty;
    logic [MW-1:0]             m_data;

    int n_cmp = 0, n_bad = 0, n_pop = 0, n_ena = 0, n_rd = 0;
    int delay = 3;
    int cd [NUM_ADC] = '{default: 0};
    logic [NUM_ADC-1:0] never = '0;
    bit sb_en = 1'b1;
    logic [MW-1:0] exp_q [$];

    adc_sample_sequencer #(
        .NUM_ADC(NUM_ADC), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W),
        .TIMEOUT(TIMEOUT), .FIFO_ABITS(FIFO_ABITS)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .period(period),
        .ch_mask(ch_mask), .clear_err(clear_err), .spi_ena(spi_ena),
        .spi_fin(spi_fin), .spi_data(spi_data), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .busy(busy), .round_done(round_done),
        .overrun(overrun), .timeout_err(timeout_err), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty)
    );

    always #5 clock = ~clock;

    // SPI responder: fin arrives 'delay' cycles after ena; expected word queued at fin time.
    initial begin
        spi_fin  = '0;
        spi_data = '0;
        forever begin
            @(posedge clock);
            #1;
            spi_fin = '0;
            for (int i = 0; i < NUM_ADC; i++) spi_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            for (int i = 0; i < NUM_ADC; i++) begin
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) begin
                        spi_fin[i] = 1'b1;
                        if (sb_en) exp_q.push_back({CH_W'(i), spi_data[i*DATA_W +: DATA_W]});
                    end
                end
            end
            for (int i = 0; i < NUM_ADC; i++) begin
                if (spi_ena[i] === 1'b1 && !never[i]) cd[i] = delay;
            end
        end
    end

    // Output monitor and event counters.
    initial begin
        logic [MW-1:0] want;
        forever begin
            @(negedge clock);
            if (spi_ena !== '0 && spi_ena !== 'x) n_ena++;
            if (round_done === 1'b1) n_rd++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_pop++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL word_unexpected got=%h want=none", m_data);
                end else begin
                    want = exp_q.pop_front();
                    if (m_data !== want) begin
                        n_bad++;
                        $display("FAIL word_data got=%h want=%h", m_data, want);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (busy === 1'b0 && fifo_empty === 1'b1) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s_idle_wait busy=%b empty=%b want busy=0 empty=1", nm, busy, fifo_empty);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear_err = 1'b0; m_ready = 1'b1;
        period = 16'd9; ch_mask = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({spi_ena, m_valid, busy, round_done, overrun, timeout_err, fifo_full} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {spi_ena, m_valid, busy, round_done, overrun, timeout_err, fifo_full});
        end
        n_cmp++;
        if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", fifo_empty); end
        n_cmp++;
        if (m_data !== '0) begin n_bad++; $display("FAIL reset_mdata got=%h want=0", m_data); end
    endtask

    task automatic test_periodic();
        int last = -1, seen = 0, rd0;
        period = 16'd9; ch_mask = 5'b00101; delay = 3; m_ready = 1'b1;
        step();
        rd0 = n_rd;
        for (int c = 0; c < 45; c++) begin
            step();
            enable = 1'b1;
            @(negedge clock);
            if (spi_ena !== '0) begin
                n_cmp++;
                if (spi_ena !== 5'b00101) begin n_bad++; $display("FAIL ena_mask got=%b want=00101", spi_ena); end
                n_cmp++;
                if (c != ((last < 0) ? 10 : last + 10)) begin
                    n_bad++; $display("FAIL ena_cycle got=%0d want=%0d", c, (last < 0) ? 10 : last + 10);
                end
                last = c;
                seen++;
            end
        end
        step();
        enable = 1'b0;
        wait_idle("periodic");
        step();
        n_cmp++;
        if (seen != 4) begin n_bad++; $display("FAIL ena_count got=%0d want=4", seen); end
        n_cmp++;
        if (n_rd - rd0 != 4) begin n_bad++; $display("FAIL round_done_count got=%0d want=4", n_rd - rd0); end
    endtask

    task automatic test_overrun();
        int e0;
        period = 16'd3; ch_mask = 5'b00101; delay = 20; m_ready = 1'b1;
        step();
        e0 = n_ena;
        for (int c = 0; c < 24; c++) begin
            step();
            enable    = 1'b1;
            clear_err = (c >= 9 && c <= 14);
            @(negedge clock);
            if (c == 8) begin
                n_cmp++;
                if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
            end
            if (c == 11) begin
                n_cmp++;
                if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got=%b want=0", overrun); end
            end
            if (c == 12) begin
                n_cmp++;
                if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set_wins got=%b want=1", overrun); end
            end
        end
        step();
        enable = 1'b0; clear_err = 1'b0;
        n_cmp++;
        if (n_ena - e0 != 1) begin n_bad++; $display("FAIL overrun_extra_ena got=%0d want=1", n_ena - e0); end
        wait_idle("overrun");
        step();
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_cleared got=%b want=0", overrun); end
    endtask

    task automatic test_timeout();
        int p0, c_ena = -1, c_to = -1;
        period = 16'd5; ch_mask = 5'b11111; never = 5'b01000; delay = 3; m_ready = 1'b1;
        step();
        p0 = n_pop;
        for (int c = 0; c < 120; c++) begin
            step();
            enable = (c_ena < 0);
            @(negedge clock);
            if (spi_ena !== '0 && c_ena < 0) c_ena = c;
            if (timeout_err === 1'b1 && c_to < 0) c_to = c;
        end
        wait_idle("timeout");
        step();
        n_cmp++;
        if (c_ena != 6) begin n_bad++; $display("FAIL timeout_ena_cycle got=%0d want=6", c_ena); end
        n_cmp++;
        if (c_to != c_ena + TIMEOUT) begin
            n_bad++; $display("FAIL timeout_cycle got=%0d want=%0d", c_to, c_ena + TIMEOUT);
        end
        n_cmp++;
        if (n_pop - p0 != 4) begin n_bad++; $display("FAIL timeout_words got=%0d want=4", n_pop - p0); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        never = '0;
        @(negedge clock);
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_cleared got=%b want=0", timeout_err); end
    endtask

    task automatic test_backpressure();
        int p0, e0;
        period = 16'd9; ch_mask = 5'b11111; delay = 3; m_ready = 1'b0;
        step();
        p0 = n_pop;
        e0 = n_ena;
        for (int c = 0; c < 60; c++) begin
            step();
            enable = 1'b1;
        end
        @(negedge clock);
        n_cmp++;
        if ({fifo_full, m_valid, busy} !== 3'b111) begin
            n_bad++; $display("FAIL bp_held got full/valid/busy=%b want=111", {fifo_full, m_valid, busy});
        end
        step();
        n_cmp++;
        if (n_pop - p0 != 0 || n_ena - e0 != 1) begin
            n_bad++; $display("FAIL bp_stall got pops=%0d enas=%0d want 0/1", n_pop - p0, n_ena - e0);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 300 && (n_ena - e0) < 3; c++) step();
        enable = 1'b0;
        n_cmp++;
        if (n_ena - e0 != 3) begin n_bad++; $display("FAIL bp_rounds got=%0d want=3", n_ena - e0); end
        wait_idle("backpressure");
        step();
        n_cmp++;
        if (n_pop - p0 != 15) begin n_bad++; $display("FAIL bp_words got=%0d want=15", n_pop - p0); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
    endtask

    task automatic test_reset_midround();
        int bad = 0;
        period = 16'd3; ch_mask = 5'b11111; delay = 10; m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            enable = 1'b1;
            if (c == 6) begin
                reset = 1'b1; enable = 1'b0; sb_en = 1'b0;
            end
            @(negedge clock);
            if (c == 5) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got=%b want=1", busy); end
            end
        end
        step();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({spi_ena, m_valid, busy, round_done, overrun, timeout_err, fifo_full, fifo_empty} !== 12'b1) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got=%b want=%b",
                     {spi_ena, m_valid, busy, round_done, overrun, timeout_err, fifo_full, fifo_empty}, 12'b1);
        end
        for (int c = 0; c < 25; c++) begin
            step();
            @(negedge clock);
            if (m_valid !== 1'b0 || busy !== 1'b0 || spi_ena !== '0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL rst_mid_late_fin got=%0d active cycles want=0", bad); end
        sb_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_overrun();
        test_timeout();
        test_backpressure();
        test_reset_midround();
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL words_left got=%0d want=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
